// File: rtl/sap_ir_pkg.sv
// Shared types and helpers for the multi-byte SAP instruction register:
// the assembly FSM state type, the opcode-to-operand-count table and the
// default bus fill value.
package sap_ir_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPERAND = 2'd1,
        READY   = 2'd2
    } ir_state_e;

    // Undriven bus value; callers slice this down to their word width.
    localparam logic [63:0] IR_FILL_DEFAULT = 64'hFFFF_FFFF_FFFF_FFFF;

    // Operand count for an opcode of width opw, clamped to max_ops.
    // MSB=0 -> 0, top bits 10 -> 1, top bits 11 -> 2, all-ones (HLT) -> 0.
    function automatic int op_len(input logic [31:0] opcode, input int opw, input int max_ops);
        logic [31:0] mask;
        logic [31:0] top;
        logic [31:0] next_bit;
        int          len;
        mask     = (32'd1 << opw) - 32'd1;
        top      = opcode >> (opw - 1);
        next_bit = opcode >> (opw - 2);
        if ((opcode & mask) == mask) begin
            len = 0;
        end else if (top[0] == 1'b0) begin
            len = 0;
        end else if (opw < 2) begin
            len = 1;
        end else if (next_bit[0] == 1'b0) begin
            len = 1;
        end else begin
            len = 2;
        end
        if (len > max_ops) begin
            len = max_ops;
        end
        return len;
    endfunction

endpackage

// File: rtl/ir_operand_len_decode.sv
// Combinational opcode-to-operand-count decoder. Kept as its own block so a
// SAP variant can swap the length table without touching the register.
module ir_operand_len_decode
    import sap_ir_pkg::*;
#(
    parameter int OPCODE_W     = 4,
    parameter int MAX_OPERANDS = 2,
    parameter int CNT_W        = 2
) (
    input  logic [OPCODE_W-1:0] i_opcode,
    output logic [CNT_W-1:0]    o_len
);

    // Table lookup with clamping to the configured operand limit.
    always_comb begin
        o_len = CNT_W'(op_len(32'(i_opcode), OPCODE_W, MAX_OPERANDS));
    end

endmodule

// File: rtl/instr_assembly_register.sv
// Multi-byte instruction register: captures an opcode word from the W bus,
// collects its operand words, and hands the assembled instruction to the
// controller with an instr_ready/consume handshake.
// Optional feature macro: IR_FLUSH_EN adds a synchronous flush input that
// abandons a partial instruction while keeping opcode/imm.
module instr_assembly_register
    import sap_ir_pkg::*;
#(
    parameter int                WORD_W       = 8,
    parameter int                OPCODE_W     = 4,
    parameter int                MAX_OPERANDS = 2,
    parameter logic [WORD_W-1:0] FILL_VAL     = IR_FILL_DEFAULT[WORD_W-1:0]
) (
    input  logic                                CLK,
    input  logic                                CLR,
    input  logic                                Li_bar,
    input  logic                                Ei_bar,
    input  logic                                consume,
`ifdef IR_FLUSH_EN
    input  logic                                flush,
`endif
    input  logic [WORD_W-1:0]                   bus_in,
    output logic [OPCODE_W-1:0]                 opcode_out,
    output logic [WORD_W-OPCODE_W-1:0]          imm_out,
    output logic [MAX_OPERANDS*WORD_W-1:0]      operands_out,
    output logic [$clog2(MAX_OPERANDS+1)-1:0]   n_operands,
    output logic                                instr_ready,
    output logic                                busy,
    output logic                                overrun,
    output logic [WORD_W-1:0]                   bus_out
);

    localparam int CNT_W = $clog2(MAX_OPERANDS + 1);
    localparam int IMM_W = WORD_W - OPCODE_W;

    ir_state_e                    r_state;
    ir_state_e                    w_next_state;
    logic [OPCODE_W-1:0]          r_opcode;
    logic [IMM_W-1:0]             r_imm;
    logic [MAX_OPERANDS*WORD_W-1:0] r_operands;
    logic [CNT_W-1:0]             r_n_ops;
    logic [CNT_W-1:0]             r_idx;
    logic                         r_ready;
    logic                         r_busy;
    logic                         r_overrun;

    logic                         w_load;
    logic                         w_flush;
    logic [CNT_W-1:0]             w_len;
    logic                         w_cap_op;
    logic                         w_cap_operand;
    logic                         w_set_ovr;
    logic                         w_clear;

    assign w_load = ~Li_bar;

`ifdef IR_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    ir_operand_len_decode #(
        .OPCODE_W     (OPCODE_W),
        .MAX_OPERANDS (MAX_OPERANDS),
        .CNT_W        (CNT_W)
    ) u_len_decode (
        .i_opcode (bus_in[WORD_W-1 -: OPCODE_W]),
        .o_len    (w_len)
    );

    // Assembly state register.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and datapath control; flush outranks load and consume.
    always_comb begin
        w_next_state  = r_state;
        w_cap_op      = 1'b0;
        w_cap_operand = 1'b0;
        w_set_ovr     = 1'b0;
        w_clear       = 1'b0;
        if (w_flush) begin
            w_next_state = IDLE;
            w_clear      = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        w_cap_op     = 1'b1;
                        w_next_state = (w_len == '0) ? READY : OPERAND;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                OPERAND: begin
                    if (w_load) begin
                        w_cap_operand = 1'b1;
                        if ((r_idx + CNT_W'(1)) == r_n_ops) begin
                            w_next_state = READY;
                        end else begin
                            w_next_state = OPERAND;
                        end
                    end else begin
                        w_next_state = OPERAND;
                    end
                end
                READY: begin
                    if (consume && w_load) begin
                        // Back-to-back: the load is the next opcode.
                        w_cap_op     = 1'b1;
                        w_next_state = (w_len == '0) ? READY : OPERAND;
                    end else if (consume) begin
                        w_next_state = IDLE;
                    end else if (w_load) begin
                        w_set_ovr    = 1'b1;
                        w_next_state = READY;
                    end else begin
                        w_next_state = READY;
                    end
                end
                default: begin
                    w_next_state = IDLE;
                end
            endcase
        end
    end

    // Instruction fields, handshake flags and sticky overrun.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_opcode   <= '0;
            r_imm      <= '0;
            r_operands <= '0;
            r_n_ops    <= '0;
            r_idx      <= '0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_ready <= (w_next_state == READY);
            r_busy  <= (w_next_state == OPERAND);
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
            if (w_clear) begin
                r_operands <= '0;
                r_n_ops    <= '0;
                r_idx      <= '0;
            end else if (w_cap_op) begin
                r_opcode   <= bus_in[WORD_W-1 -: OPCODE_W];
                r_imm      <= bus_in[IMM_W-1:0];
                r_operands <= '0;
                r_n_ops    <= w_len;
                r_idx      <= '0;
            end else if (w_cap_operand) begin
                for (int k = 0; k < MAX_OPERANDS; k++) begin
                    if (r_idx == CNT_W'(k)) begin
                        r_operands[k*WORD_W +: WORD_W] <= bus_in;
                    end
                end
                r_idx <= r_idx + CNT_W'(1);
            end
        end
    end

    // Bus drive: first operand if any, otherwise the zero-extended immediate.
    always_comb begin
        if (Ei_bar) begin
            bus_out = FILL_VAL;
        end else if (r_n_ops != '0) begin
            bus_out = r_operands[WORD_W-1:0];
        end else begin
            bus_out = WORD_W'(r_imm);
        end
    end

    assign opcode_out   = r_opcode;
    assign imm_out      = r_imm;
    assign operands_out = r_operands;
    assign n_operands   = r_n_ops;
    assign instr_ready  = r_ready;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule

// File: doc/instr_assembly_register.md
Name: instr_assembly_register

Overview:
Parametrised instruction register for the multi-byte SAP generation. It captures an opcode word from the W bus, then collects 0..MAX_OPERANDS operand words on later load strobes. It presents the assembled instruction to the control unit with a ready/consume handshake. The low field (immediate or first operand) is driven toward the bus under an active-low enable. It sits between the W bus and the controller/sequencer, replacing the single-byte nibble-split register.

Parameters:
- WORD_W, 8, W-bus width in bits.
- OPCODE_W, 4, opcode field width; the opcode occupies bus_in[WORD_W-1 -: OPCODE_W].
- MAX_OPERANDS, 2, maximum operand words per instruction (≥1).
- FILL_VAL, all-ones of WORD_W, value on bus_out when it is not enabled.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  asynchronous reset, active-high.
- Li_bar  in  1  load strobe, active-low; sampled at the rising CLK edge.
- Ei_bar  in  1  output enable for bus_out, active-low, combinational.
- consume  in  1  controller has taken the instruction (active-high, one cycle).
- bus_in  in  WORD_W  W-bus data.
- opcode_out  out  OPCODE_W  latched opcode.
- imm_out  out  WORD_W-OPCODE_W  low field of the opcode word.
- operands_out  out  MAX_OPERANDS*WORD_W  operand slots; slot k is at [k*WORD_W +: WORD_W].
- n_operands  out  $clog2(MAX_OPERANDS+1)  operand count of the current instruction.
- instr_ready  out  1  assembled instruction is valid.
- busy  out  1  operand collection is in progress.
- overrun  out  1  sticky error: a load arrived while in READY without consume.
- bus_out  out  WORD_W  field driven to the bus.

Behaviour:
- Reset (CLR high, asynchronous) forces:
  - state IDLE;
  - opcode_out, imm_out, operands_out, n_operands all zero;
  - instr_ready=0, busy=0, overrun=0.
- States are IDLE, OPERAND and READY. A "load" means Li_bar=0 at a rising edge.
- IDLE:
  - On a load, latch opcode and imm from bus_in, clear all operand slots, set n_operands=len(opcode), reset the slot index to 0.
  - If len=0, go to READY. Otherwise go to OPERAND.
- OPERAND:
  - busy=1.
  - Each load writes bus_in into slot[idx], then idx++.
  - When idx+1==n_operands, go to READY on the same edge.
  - Cycles without a load hold state; there is no timeout.
- READY:
  - instr_ready=1.
  - consume=1 returns to IDLE on the next edge; fields are retained until the next opcode load.
  - consume=1 together with a load is treated as back-to-back: the load is taken as a new opcode, as in IDLE. The latency of one instruction is unaffected.
  - A load without consume is ignored, fields are unchanged, and overrun is set. overrun clears only on CLR.
- consume in IDLE or OPERAND is ignored.
- len(opcode), clamped to MAX_OPERANDS:
  - opcode MSB=0 gives 0;
  - top two bits 2'b10 give 1;
  - top two bits 2'b11 give 2;
  - all-ones opcode gives 0 (HLT).
- Output timing: all outputs except bus_out are registered and update on the capturing edge. instr_ready asserts in the cycle after the final word is loaded.
- bus_out is combinational:
  - Ei_bar=1 gives FILL_VAL.
  - Ei_bar=0 with n_operands>0 gives slot 0.
  - Ei_bar=0 with n_operands=0 gives imm_out zero-extended to WORD_W.
- CLR during OPERAND abandons the partial instruction; no partial instr_ready is ever produced.

Optional Feature:
IR_FLUSH_EN:
- Defined: adds input flush (1 bit, active-high, synchronous). Flush at an edge forces IDLE and clears operand slots and n_operands. Opcode and imm are kept, overrun is unaffected. Flush has priority over load and consume in the same cycle.
- Undefined: the port is absent and the only abort is CLR.

Decomposition:
- Package sap_ir_pkg holds:
  - the state enum type (IDLE/OPERAND/READY);
  - the function op_len(opcode, OPCODE_W, MAX_OPERANDS) implementing the table with clamping;
  - the default fill constant.
- Sub-module ir_operand_len_decode: combinational opcode to operand count; it wraps op_len so the table can be swapped per SAP variant.

Test Plan:
- Reset then load 8'h3A (defaults): opcode_out=3, imm_out=A, n_operands=0; next cycle instr_ready=1. With Ei_bar=0, bus_out=8'h0A; with Ei_bar=1, bus_out=8'hFF.
- Load 8'hC5, 8'h12, 8'h34 on three consecutive edges:
  - busy=1 for two cycles;
  - then instr_ready=1, opcode=C, operands_out=16'h3412;
  - with Ei_bar=0, bus_out=8'h12.
- In READY, load 8'h81 without consume: fields unchanged, overrun=1 and stays 1; a later consume reaches IDLE.
- In READY, consume=1 with a load of 8'h8F, then a load of 8'h77: new instr_ready after one cycle with opcode=8, slot0=8'h77. No gap in throughput.
- Load 8'hC0 and 8'h11, then assert CLR mid-OPERAND: all outputs zero at once and state is IDLE. The next load of 8'hF0 gives instr_ready with n_operands=0 (HLT).
- With IR_FLUSH_EN: load 8'hC0, then flush=1 and Li_bar=0 in the same cycle: result is IDLE, busy=0, slots zero, no capture.
